// File: rtl/sort_unloader_if.sv
// Interface between the bitonic network output, the unloader and its narrow consumer.
// The master modport is the unloader side; the slave modport is the network/consumer side.
interface sort_unloader_if #(
  parameter int DATA_WIDTH = 4,
  parameter int LOG_INPUT  = 3
);
  logic                                      y_valid;
  logic [0:DATA_WIDTH*(1<<LOG_INPUT)-1]      d_in;
  logic [DATA_WIDTH-1:0]                     m_data;
  logic                                      m_valid;
  logic                                      m_ready;
  logic                                      m_last;
  logic                                      busy;
  logic                                      overflow;
  logic                                      clr_overflow;

  modport master (
    input  y_valid, d_in, m_ready, clr_overflow,
    output m_data, m_valid, m_last, busy, overflow
  );

  modport slave (
    output y_valid, d_in, m_ready, clr_overflow,
    input  m_data, m_valid, m_last, busy, overflow
  );
endinterface

// File: rtl/sort_unloader.sv
// Captures a sorted vector from the last sort stage and streams it out one element per beat.
// Vectors arriving mid-drain are dropped and flagged in a sticky overflow bit.
module sort_unloader #(
  parameter int DATA_WIDTH = 4,
  parameter int LOG_INPUT  = 3,
  parameter int REVERSE    = 0
) (
  input  logic           clk,
  input  logic           rst,
  sort_unloader_if.master bus
);
  localparam int N = 1 << LOG_INPUT;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam logic [LOG_INPUT-1:0] IDX_FIRST = (REVERSE != 0) ? {LOG_INPUT{1'b1}} : {LOG_INPUT{1'b0}};
  localparam logic [LOG_INPUT-1:0] IDX_LAST  = (REVERSE != 0) ? {LOG_INPUT{1'b0}} : {LOG_INPUT{1'b1}};

  logic [0:0]               state;
  logic [0:DATA_WIDTH*N-1]  hold;
  logic [LOG_INPUT-1:0]     idx;
  logic                     overflow_q;
  logic                     at_last;
  logic                     beat;
  logic                     last_beat;
  logic                     drop;
  logic [DATA_WIDTH-1:0]    m_data_c;

  always_comb begin
    at_last   = (idx == IDX_LAST);
    beat      = (state == S_DRAIN) && bus.m_ready;
    last_beat = beat && at_last;
    // Only a completing last beat can absorb a new vector; anything else in DRAIN is lost.
    drop      = (state == S_DRAIN) && bus.y_valid && !last_beat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hold       <= '0;
      idx        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (drop)
        overflow_q <= 1'b1;
      else if (bus.clr_overflow)
        overflow_q <= 1'b0;

      if (state == S_IDLE) begin
        if (bus.y_valid) begin
          hold  <= bus.d_in;
          idx   <= IDX_FIRST;
          state <= S_DRAIN;
        end
      end else begin
        if (last_beat) begin
          if (bus.y_valid) begin
            hold <= bus.d_in;
            idx  <= IDX_FIRST;
          end else begin
            state <= S_IDLE;
          end
        end else if (beat) begin
          if (REVERSE != 0)
            idx <= idx - LOG_INPUT'(1);
          else
            idx <= idx + LOG_INPUT'(1);
        end
      end
    end
  end

  always_comb begin
    m_data_c = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == LOG_INPUT'(k))
        m_data_c = hold[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.m_data   = m_data_c;
  assign bus.m_valid  = (state == S_DRAIN);
  assign bus.busy     = (state == S_DRAIN);
  assign bus.m_last   = (state == S_DRAIN) && at_last;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_sort_unloader.sv
// Directed bench for sort_unloader: forward instance for streaming/back-pressure/drop cases,
// reverse instance for REVERSE ordering and asynchronous reset mid-drain.
module tb_sort_unloader;
  logic clk;
  logic rst;
  logic rst_r;
  int   total;
  int   passed;

  sort_unloader_if #(.DATA_WIDTH(4), .LOG_INPUT(3)) f_if ();
  sort_unloader_if #(.DATA_WIDTH(4), .LOG_INPUT(3)) r_if ();

  sort_unloader #(.DATA_WIDTH(4), .LOG_INPUT(3), .REVERSE(0)) u_fwd (
    .clk (clk),
    .rst (rst),
    .bus (f_if.master)
  );

  sort_unloader #(.DATA_WIDTH(4), .LOG_INPUT(3), .REVERSE(1)) u_rev (
    .clk (clk),
    .rst (rst_r),
    .bus (r_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Element k of the vector is (base + k) truncated to 4 bits.
  function automatic logic [0:31] vec(input int base);
    logic [0:31] v;
    for (int k = 0; k < 8; k++) v[k*4 +: 4] = 4'(base + k);
    return v;
  endfunction

  // Drives the forward instance's m_ready from pat (bit c = cycle c, then 1s) and checks every
  // cycle until nbeats are consumed; optionally pulses a new vector on beat inj_beat.
  task automatic drain(input int first, input int nbeats, input logic [15:0] pat, input int patlen,
                       input int inj_beat, input int inj_base);
    int b;
    int c;
    b = 0;
    c = 0;
    while (b < nbeats && c < 200) begin
      @(negedge clk);
      f_if.y_valid = 1'b0;
      chk("fwd_valid", 32'(f_if.m_valid), 1);
      chk("fwd_data", 32'(f_if.m_data), 32'((first + b) & 15));
      chk("fwd_last", 32'(f_if.m_last), 32'((b % 8) == 7));
      f_if.m_ready = (c < patlen) ? pat[c] : 1'b1;
      if (b == inj_beat && f_if.m_ready) begin
        f_if.y_valid = 1'b1;
        f_if.d_in    = vec(inj_base);
      end
      if (f_if.m_ready) b++;
      c++;
    end
    chk("fwd_beat_count", 32'(b), 32'(nbeats));
  endtask

  task automatic fwd_idle_check();
    @(negedge clk);
    f_if.y_valid = 1'b0;
    chk("fwd_valid_fall", 32'(f_if.m_valid), 0);
    chk("fwd_busy_fall", 32'(f_if.busy), 0);
    chk("fwd_last_fall", 32'(f_if.m_last), 0);
  endtask

  task automatic fwd_pulse(input int base);
    @(negedge clk);
    f_if.y_valid = 1'b1;
    f_if.d_in    = vec(base);
  endtask

  task automatic rev_drain(input int base, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      r_if.y_valid = 1'b0;
      chk("rev_valid", 32'(r_if.m_valid), 1);
      chk("rev_data", 32'(r_if.m_data), 32'((base + 7 - b) & 15));
      chk("rev_last", 32'(r_if.m_last), 32'(b == 7));
    end
  endtask

  initial begin
    int w;
    total = 0;
    passed = 0;
    rst = 1'b1;
    rst_r = 1'b1;
    f_if.y_valid = 1'b0; f_if.d_in = '0; f_if.m_ready = 1'b1; f_if.clr_overflow = 1'b0;
    r_if.y_valid = 1'b0; r_if.d_in = '0; r_if.m_ready = 1'b1; r_if.clr_overflow = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(f_if.m_valid), 0);
    chk("rst_last", 32'(f_if.m_last), 0);
    chk("rst_busy", 32'(f_if.busy), 0);
    chk("rst_overflow", 32'(f_if.overflow), 0);
    chk("rst_data", 32'(f_if.m_data), 0);
    rst = 1'b0;
    rst_r = 1'b0;
    @(negedge clk);
    chk("idle_no_valid", 32'(f_if.m_valid), 0);

    // Single vector, m_ready held high
    fwd_pulse(1);
    drain(1, 8, 16'h0001, 1, -1, 0);
    fwd_idle_check();

    // Back-pressure pattern 1,0,0,1,1,0,1,1,1,1
    fwd_pulse(1);
    drain(1, 8, 16'b0000_0011_1101_1001, 10, -1, 0);
    fwd_idle_check();

    // Back-to-back: second vector on the last beat, 16 contiguous beats (16 wraps to 0)
    fwd_pulse(1);
    drain(1, 16, 16'h0001, 1, 7, 9);
    fwd_idle_check();
    chk("b2b_no_overflow", 32'(f_if.overflow), 0);

    // Drop on beat 3
    fwd_pulse(1);
    drain(1, 8, 16'h0001, 1, 2, 9);
    fwd_idle_check();
    chk("drop_overflow", 32'(f_if.overflow), 1);

    // Set wins over clear, then a clear alone releases the flag
    f_if.m_ready = 1'b0;
    fwd_pulse(1);
    @(negedge clk);
    f_if.y_valid = 1'b1;
    f_if.d_in = vec(9);
    f_if.clr_overflow = 1'b1;
    @(negedge clk);
    f_if.y_valid = 1'b0;
    f_if.clr_overflow = 1'b0;
    chk("set_beats_clear", 32'(f_if.overflow), 1);
    chk("stall_data_hold", 32'(f_if.m_data), 1);
    f_if.clr_overflow = 1'b1;
    @(negedge clk);
    f_if.clr_overflow = 1'b0;
    chk("clear_alone", 32'(f_if.overflow), 0);
    f_if.m_ready = 1'b1;
    w = 0;
    while (f_if.m_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("drain_finishes", 32'(f_if.m_valid), 0);

    // REVERSE ordering
    @(negedge clk);
    r_if.y_valid = 1'b1;
    r_if.d_in = vec(1);
    rev_drain(1, 8);
    @(negedge clk);
    chk("rev_valid_fall", 32'(r_if.m_valid), 0);

    // Asynchronous reset after the third beat
    r_if.y_valid = 1'b1;
    r_if.d_in = vec(1);
    rev_drain(1, 3);
    @(posedge clk);
    #2;
    rst_r = 1'b1;
    #1;
    chk("arst_valid", 32'(r_if.m_valid), 0);
    chk("arst_busy", 32'(r_if.busy), 0);
    chk("arst_last", 32'(r_if.m_last), 0);
    @(negedge clk);
    rst_r = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(r_if.m_valid), 0);
    r_if.y_valid = 1'b1;
    r_if.d_in = vec(5);
    rev_drain(5, 8);
    @(negedge clk);
    chk("post_rst_done", 32'(r_if.m_valid), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sort_unloader.md
# sort_unloader

Output stage placed directly after the last `sort_stage` of the bitonic network. It captures a full sorted vector on the network's `y_valid` and streams it out one element per beat over a valid/ready interface. This lets a narrow downstream consumer with back-pressure drain the wide network output. The network itself has no back-pressure, so vectors that arrive while the unloader is still draining are dropped and flagged.

## Interface
- `DATA_WIDTH`, default 4: width of one element.
- `LOG_INPUT`, default 3: log2 of elements per vector; N = 2**LOG_INPUT. Must be ≥ 1.
- `REVERSE`, default 0: 0 streams element 0 first; 1 streams element N-1 first.
- `clk`, input, 1: clock. One clock domain; all logic is rising-edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `y_valid`, input, 1: one-cycle pulse from the last sort stage; `d_in` is valid in that cycle.
- `d_in`, input, `[0:DATA_WIDTH*N-1]`: sorted vector. Element k is `d_in[k*DATA_WIDTH:(k+1)*DATA_WIDTH-1]`.
- `m_data`, output, DATA_WIDTH: current element.
- `m_valid`, output, 1: `m_data` is valid.
- `m_ready`, input, 1: consumer accepts the beat.
- `m_last`, output, 1: the current beat is the final element of the vector.
- `busy`, output, 1: the holding register is occupied (state DRAIN).
- `overflow`, output, 1: sticky flag; a vector was dropped.
- `clr_overflow`, input, 1: synchronous clear of `overflow`.

## Operation
- **Storage**
  - Holding register `hold` of DATA_WIDTH*N bits.
  - Beat counter `idx` of LOG_INPUT bits.
  - State is IDLE or DRAIN.
- **IDLE**
  - If `y_valid`=1: load `hold` with `d_in`, set `idx` to 0 (N-1 if REVERSE), go to DRAIN.
- **DRAIN**
  - `m_valid`=1.
  - `m_data` = element `idx` of `hold`.
  - `m_last`=1 when `idx` = N-1 (0 if REVERSE).
- **Beat** (`m_valid` and `m_ready` both 1)
  - Not last: `idx` increments (decrements if REVERSE).
  - Last and `y_valid`=0: go to IDLE.
  - Last and `y_valid`=1 in the same cycle: reload `hold` from `d_in`, reset `idx`, stay in DRAIN. This is back-to-back with no bubble.
- **Drop rule**
  - `y_valid`=1 while in DRAIN, other than on a completing last beat: the vector is discarded.
  - `hold` and `idx` are unchanged, and `overflow` is set.
- **overflow clear**
  - `clr_overflow`=1 clears `overflow`.
  - If a set event happens in the same cycle, the set wins.
- **Stable data**
  - `m_data` and `m_last` hold their values while `m_valid`=1 and `m_ready`=0.
- `m_ready` has no effect in IDLE.
- `idx` never wraps past the end of the vector; the last beat always terminates or reloads.

## Timing
- **Reset values:** state=IDLE, `m_valid`=0, `m_last`=0, `busy`=0, `overflow`=0, `idx`=0, `m_data`=0, `hold`=0.
- **Reset mid-drain:** `rst` asserted during DRAIN aborts immediately and asynchronously. The partial vector is lost and no further beats are issued.
- **First-beat latency:** a `y_valid` captured at edge t gives `m_valid`=1 with element 0 (or N-1) in the cycle after t.
- **Minimum drain time:** N cycles with `m_ready` held at 1.
- **Throughput:** one vector per N cycles, reached when `y_valid` coincides with the last beat.
- **Outputs:** `m_valid`, `busy` and `overflow` are registered. `m_data` and `m_last` are a mux driven only by registers, with no input-to-output combinational path.
- **m_ready:** may toggle freely. Only beats with `m_valid` and `m_ready` both 1 are consumed.

## Test plan
- **Single vector:** DATA_WIDTH=4, LOG_INPUT=3, `d_in` elements 0..7 = 1,2,3,4,5,6,7,8, `m_ready`=1, one `y_valid` pulse.
  - Required: the cycle after the pulse starts 8 consecutive beats 1..8.
  - `m_last` is high only on 8; `m_valid` falls the cycle after.
- **Back-pressure:** same vector, `m_ready` pattern 1,0,0,1,1,0,1,1,1,1.
  - Required: beats are 1..8 in order, and `m_data` is stable during every stall.
- **Back-to-back:** a second `y_valid` carrying 9..16 is pulsed exactly on the last-beat cycle of the first vector.
  - Required: 16 contiguous beats 1..16 with no bubble, and `overflow` stays 0.
- **Drop:** a second `y_valid` is pulsed at beat 3 of the first vector.
  - Required: the output is only 1..8 and `overflow` goes to 1.
  - Asserting `clr_overflow` in the same cycle as a further drop leaves `overflow`=1; a clear alone then returns it to 0.
- **REVERSE and reset:** with REVERSE=1, the output is 8,7,...,1 and `m_last` is on 1.
  - Asserting `rst` after the 3rd beat forces `m_valid`, `busy` and `m_last` to 0 immediately.
  - The next `y_valid` is then captured normally.
